// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences a fixed 18-word program ROM through IDLE/RUN/HALT,
// with stall, single-step, restart/abort control and a saturating issue counter.
module instr_fetch #(
  parameter int unsigned PROG_LEN = 32'd18,
  parameter int unsigned PC_W     = 32'd5,
  parameter bit          LOOP     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            stall,
  input  logic            step_mode,
  input  logic            step,
  output logic [15:0]     ReadInstr,
  output logic [PC_W-1:0] PC,
  output logic            InstrValid,
  output logic            Halted,
  output logic [7:0]      InstrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 32'd1);

  // Program ROM; words past the program end read as zero.
  function automatic logic [15:0] rom_word(input logic [PC_W-1:0] addr);
    logic [31:0] idx;
    logic [15:0] word;
    idx = 32'(addr);
    case (idx)
      32'd0:   word = 16'hA100;
      32'd1:   word = 16'hD1FE;
      32'd2:   word = 16'hD1FF;
      32'd3:   word = 16'h1C80;
      32'd4:   word = 16'hF900;
      32'd5:   word = 16'hA906;
      32'd6:   word = 16'hD9FE;
      32'd7:   word = 16'hD9FF;
      32'd8:   word = 16'h00C0;
      32'd9:   word = 16'h2B01;
      32'd10:  word = 16'hD3FE;
      32'd11:  word = 16'hD3FF;
      32'd12:  word = 16'hB905;
      32'd13:  word = 16'h0A80;
      32'd14:  word = 16'h3F01;
      32'd15:  word = 16'h3040;
      32'd16:  word = 16'hCF00;
      32'd17:  word = 16'h0280;
      default: word = 16'h0000;
    endcase
    rom_word = (idx < PROG_LEN) ? word : 16'h0000;
  endfunction

  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [15:0]     instr_r, instr_s;
  logic            valid_r, valid_s;
  logic            halted_r, halted_s;
  logic [7:0]      count_r, count_s;
  logic            advance_s;
  logic [7:0]      count_inc_s;

  // Next-state and next-output computation; stop outranks start, which outranks normal sequencing.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    instr_s     = instr_r;
    valid_s     = valid_r;
    halted_s    = halted_r;
    count_s     = count_r;
    advance_s   = !stall && (!step_mode || step);
    count_inc_s = (count_r == 8'hFF) ? count_r : count_r + 8'd1;
    if (stop) begin
      state_s  = IDLE;
      pc_s     = PC_ZERO;
      instr_s  = 16'h0000;
      valid_s  = 1'b0;
      halted_s = 1'b0;
    end else if (start) begin
      state_s  = RUN;
      pc_s     = PC_ZERO;
      instr_s  = rom_word(PC_ZERO);
      valid_s  = 1'b1;
      halted_s = 1'b0;
      count_s  = 8'd1;
    end else begin
      case (state_r)
        IDLE: begin
          instr_s  = 16'h0000;
          valid_s  = 1'b0;
          halted_s = 1'b0;
        end
        RUN: begin
          if (advance_s) begin
            if (pc_r == PC_LAST) begin
              if (LOOP) begin
                pc_s    = PC_ZERO;
                instr_s = rom_word(PC_ZERO);
                count_s = count_inc_s;
              end else begin
                state_s  = HALT;
                instr_s  = 16'h0000;
                valid_s  = 1'b0;
                halted_s = 1'b1;
              end
            end else begin
              pc_s    = pc_r + PC_ONE;
              instr_s = rom_word(pc_r + PC_ONE);
              count_s = count_inc_s;
            end
          end else begin
            valid_s = 1'b1;
          end
        end
        HALT: begin
          instr_s  = 16'h0000;
          valid_s  = 1'b0;
          halted_s = 1'b1;
        end
        default: begin
          state_s  = IDLE;
          pc_s     = PC_ZERO;
          instr_s  = 16'h0000;
          valid_s  = 1'b0;
          halted_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      pc_r     <= PC_ZERO;
      instr_r  <= 16'h0000;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      count_r  <= 8'd0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      instr_r  <= instr_s;
      valid_r  <= valid_s;
      halted_r <= halted_s;
      count_r  <= count_s;
    end
  end

  assign ReadInstr  = instr_r;
  assign PC         = pc_r;
  assign InstrValid = valid_r;
  assign Halted     = halted_r;
  assign InstrCount = count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: one looping and one halting instance
// share the stimulus; expected values come from the bench's own program table.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, start, stop, stall, step_mode, step;
  logic [15:0] ri_a, ri_b;
  logic [4:0]  pc_a, pc_b;
  logic        v_a, v_b, h_a, h_b;
  logic [7:0]  cnt_a, cnt_b;

  int checks   = 0;
  int failures = 0;
  int exp_pc;
  int exp_cnt;

  logic [15:0] prog [0:17] = '{16'hA100, 16'hD1FE, 16'hD1FF, 16'h1C80, 16'hF900, 16'hA906,
                               16'hD9FE, 16'hD9FF, 16'h00C0, 16'h2B01, 16'hD3FE, 16'hD3FF,
                               16'hB905, 16'h0A80, 16'h3F01, 16'h3040, 16'hCF00, 16'h0280};

  always #5 clk = ~clk;

  instr_fetch #(.PROG_LEN(32'd18), .PC_W(32'd5), .LOOP(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stall(stall),
    .step_mode(step_mode), .step(step),
    .ReadInstr(ri_a), .PC(pc_a), .InstrValid(v_a), .Halted(h_a), .InstrCount(cnt_a)
  );

  instr_fetch #(.PROG_LEN(32'd18), .PC_W(32'd5), .LOOP(1'b0)) dut_halt (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stall(stall),
    .step_mode(step_mode), .step(step),
    .ReadInstr(ri_b), .PC(pc_b), .InstrValid(v_b), .Halted(h_b), .InstrCount(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [15:0] ri, input int pc,
                       input logic v, input logic h, input int cnt);
    chk({tag, "_instr"}, 32'(ri_a), 32'(ri));
    chk({tag, "_pc"}, 32'(pc_a), 32'(pc));
    chk({tag, "_valid"}, 32'(v_a), 32'(v));
    chk({tag, "_halted"}, 32'(h_a), 32'(h));
    chk({tag, "_count"}, 32'(cnt_a), 32'(cnt));
  endtask

  task automatic chk_b(input string tag, input logic [15:0] ri, input int pc,
                       input logic v, input logic h, input int cnt);
    chk({tag, "_instr"}, 32'(ri_b), 32'(ri));
    chk({tag, "_pc"}, 32'(pc_b), 32'(pc));
    chk({tag, "_valid"}, 32'(v_b), 32'(v));
    chk({tag, "_halted"}, 32'(h_b), 32'(h));
    chk({tag, "_count"}, 32'(cnt_b), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; stall = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_a("reset", 16'h0000, 0, 1'b0, 1'b0, 0);
    chk_b("reset_b", 16'h0000, 0, 1'b0, 1'b0, 0);
    tick();
    chk_a("idle_hold", 16'h0000, 0, 1'b0, 1'b0, 0);

    // Free run through the whole program and wrap
    start = 1'b1; tick(); start = 1'b0;
    chk_a("start", 16'hA100, 0, 1'b1, 1'b0, 1);
    for (int k = 1; k < 18; k++) begin
      tick();
      chk("run_instr", 32'(ri_a), 32'(prog[k]));
      chk("run_pc", 32'(pc_a), 32'(k));
      chk("run_count", 32'(cnt_a), 32'(k + 1));
    end
    chk_b("last_b", 16'h0280, 17, 1'b1, 1'b0, 18);
    tick();
    chk_a("wrap", 16'hA100, 0, 1'b1, 1'b0, 19);
    chk_b("halt_b", 16'h0000, 17, 1'b0, 1'b1, 18);

    // Stall at PC=4 for three cycles
    repeat (4) tick();
    chk_a("pc4", 16'hF900, 4, 1'b1, 1'b0, 23);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a("stall", 16'hF900, 4, 1'b1, 1'b0, 23);
    end
    stall = 1'b0; tick();
    chk_a("unstall", 16'hA906, 5, 1'b1, 1'b0, 24);
    chk_b("halt_sticky_b", 16'h0000, 17, 1'b0, 1'b1, 18);

    // Restart while running (and from HALT), then single-step
    start = 1'b1; step_mode = 1'b1; tick(); start = 1'b0;
    chk_a("restart", 16'hA100, 0, 1'b1, 1'b0, 1);
    chk_b("restart_b", 16'hA100, 0, 1'b1, 1'b0, 1);
    tick(); tick();
    chk_a("step_idle", 16'hA100, 0, 1'b1, 1'b0, 1);
    step = 1'b1; tick(); step = 1'b0;
    chk_a("step1", 16'hD1FE, 1, 1'b1, 1'b0, 2);
    repeat (3) tick();
    chk_a("step_hold", 16'hD1FE, 1, 1'b1, 1'b0, 2);
    step = 1'b1; stall = 1'b1; tick(); stall = 1'b0;
    chk_a("step_stall", 16'hD1FE, 1, 1'b1, 1'b0, 2);
    tick();
    chk_a("step_multi1", 16'hD1FF, 2, 1'b1, 1'b0, 3);
    tick(); step = 1'b0;
    chk_a("step_multi2", 16'h1C80, 3, 1'b1, 1'b0, 4);
    step_mode = 1'b0;

    // stop+start together at PC=9: stop wins, count held
    repeat (6) tick();
    chk_a("pc9", 16'h2B01, 9, 1'b1, 1'b0, 10);
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk_a("stop_start", 16'h0000, 0, 1'b0, 1'b0, 10);
    tick();
    chk_a("stopped_idle", 16'h0000, 0, 1'b0, 1'b0, 10);

    // Reset mid-run at PC=12, overriding a concurrent start
    start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    chk_a("pc12", 16'hB905, 12, 1'b1, 1'b0, 13);
    rst = 1'b1; start = 1'b1; stall = 1'b1; tick();
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    chk_a("mid_rst", 16'h0000, 0, 1'b0, 1'b0, 0);
    chk_b("mid_rst_b", 16'h0000, 0, 1'b0, 1'b0, 0);

    // 300 advances: count saturates, PC wraps every pass
    start = 1'b1; tick(); start = 1'b0;
    exp_pc = 0; exp_cnt = 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      exp_pc  = (exp_pc == 17) ? 0 : exp_pc + 1;
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk("sat_pc", 32'(pc_a), 32'(exp_pc));
      chk("sat_instr", 32'(ri_a), 32'(prog[exp_pc]));
      chk("sat_count", 32'(cnt_a), 32'(exp_cnt));
    end
    chk_a("sat_end", 16'hB905, 12, 1'b1, 1'b0, 255);
    chk_b("sat_halt_b", 16'h0000, 17, 1'b0, 1'b1, 18);

    // stop from HALT returns to IDLE
    stop = 1'b1; tick(); stop = 1'b0;
    chk_b("halt_stop_b", 16'h0000, 0, 1'b0, 1'b0, 18);
    chk_a("run_stop", 16'h0000, 0, 1'b0, 1'b0, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PROG_LEN, default 18, SHALL give the number of valid program words.
REQ-002 Parameter PC_W, default 5, SHALL give the PC width; PROG_LEN <= 2**PC_W.
REQ-003 Parameter LOOP, default 1, SHALL select the end-of-program action: 1 = wrap to word 0, 0 = halt.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high (ports clk and rst).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  begin or restart execution at word 0.
REQ-008 stop  input  1  abort execution and return to IDLE.
REQ-009 stall  input  1  freeze PC and ReadInstr.
REQ-010 step_mode  input  1  advance only on step pulses.
REQ-011 step  input  1  single-cycle advance request, used when step_mode=1.
REQ-012 ReadInstr  output  16  current instruction to the downstream decoder.
REQ-013 PC  output  PC_W  address of ReadInstr.
REQ-014 InstrValid  output  1  ReadInstr is a live program word.
REQ-015 Halted  output  1  FSM is in HALT.
REQ-016 InstrCount  output  8  saturating count of issued instructions.

Function
REQ-017 The ROM SHALL hold, in order from word 0: A100 D1FE D1FF 1C80 F900 A906 D9FE D9FF 00C0 2B01 D3FE D3FF B905 0A80 3F01 3040 CF00 0280 (hex); addresses >= PROG_LEN SHALL read 16'h0000.
REQ-018 The FSM SHALL have the states IDLE, RUN and HALT.
REQ-019 IDLE: ReadInstr=0000, InstrValid=0; on start, next cycle RUN, PC=0, ReadInstr=ROM[0], InstrValid=1, InstrCount=1.
REQ-020 RUN: advance = !stall && (!step_mode || step), evaluated each cycle.
REQ-021 On advance with PC < PROG_LEN-1: PC<=PC+1, ReadInstr<=ROM[PC+1], InstrCount+1, all in one cycle.
REQ-022 On advance at PC = PROG_LEN-1 with LOOP=1: PC<=0, ReadInstr<=ROM[0], InstrCount+1.
REQ-023 On advance at PC = PROG_LEN-1 with LOOP=0: go to HALT, InstrValid<=0, ReadInstr<=0000, PC held.
REQ-024 While stall=1, PC, ReadInstr and InstrCount SHALL hold and InstrValid SHALL remain 1; stall SHALL override step.
REQ-025 In step_mode, each step-high cycle SHALL advance exactly once, and a multi-cycle step SHALL advance once per high cycle.
REQ-026 HALT: Halted=1, InstrValid=0, ReadInstr=0000; start SHALL restart as from IDLE (REQ-019).
REQ-027 start while in RUN SHALL restart at word 0 next cycle and SHALL reset InstrCount to 1.
REQ-028 stop in any state SHALL go to IDLE next cycle: PC=0, ReadInstr=0000, InstrValid=0, InstrCount held.
REQ-029 When stop and start are high together, stop SHALL take priority.
REQ-030 InstrCount SHALL saturate at 255 and not wrap.
REQ-031 When InstrValid=1, ReadInstr SHALL always equal ROM[PC].
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 rst=1 SHALL force IDLE, PC=0, ReadInstr=0000, InstrValid=0, Halted=0, InstrCount=0 at the next clk edge.
REQ-034 rst SHALL override start, stop and stall in every state, including mid-program.

Verification
REQ-035 rst, then start pulse, step_mode=0 -> cycle 1 ReadInstr=A100 PC=0; cycle 2 D1FE PC=1; cycle 18 0280 PC=17; cycle 19 A100 PC=0 (LOOP=1).
REQ-036 LOOP=0, run to the end -> after 0280 (PC=17), next cycle Halted=1 InstrValid=0 ReadInstr=0000; start -> A100 PC=0.
REQ-037 At PC=4 (F900), stall high for 3 cycles -> F900 held 3 cycles, InstrCount unchanged; release -> A906 PC=5.
REQ-038 step_mode=1, step pulses at cycles 3 and 7 -> PC 0->1 at cycle 4, 1->2 at cycle 8, otherwise held; step+stall together -> no advance.
REQ-039 At PC=9, stop and start together -> IDLE, InstrValid=0, ReadInstr=0000; rst mid-run at PC=12 -> all outputs at reset values next cycle.
REQ-040 Run 300 advances with LOOP=1 -> InstrCount=255 sticky, PC wraps 17->0 correctly each pass.
